// File: rtl/chunked_addsub_unit.sv
// ============================================================================
// chunked_addsub_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Multi-cycle adder/subtractor that evaluates CHUNK result bits per clock,
//   so a wide operand never needs one long carry path. Keeps an architectural
//   carry flag (carry-in for ADC/SBC) and a stored zero flag so that wider
//   numbers can be processed one word at a time.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   CHUNK  bits computed per RUN cycle (WIDTH % CHUNK == 0)
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  request handshake (in_ready only while idle)
//   op                 00 ADD, 01 SUB, 10 ADC, 11 SBC
//   x, y               operands A and B
//   out_valid/out_ready result handshake
//   z                  result (modulo 2^WIDTH)
//   c_out              carry out of the MSB (subtract: 1 = no borrow)
//   overflow           signed overflow
//   negative           z[WIDTH-1]
//   zero               zero flag
//   carry_flag         stored architectural carry
//
// Build option:
//   ZERO_CHAIN_EN  when defined, ADC/SBC report zero only if this word and
//                  the stored zero flag of the previous word are both zero.
// ============================================================================
module chunked_addsub_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             c_out,
    output logic             overflow,
    output logic             negative,
    output logic             zero,
    output logic             carry_flag
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] yeff_q, yeff_d;
    logic [1:0]       op_q, op_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             out_valid_q, out_valid_d;
    logic             c_out_q, c_out_d;
    logic             overflow_q, overflow_d;
    logic             negative_q, negative_d;
    logic             zero_q, zero_d;
    logic             carry_flag_q, carry_flag_d;
    logic             zstore_q, zstore_d;

    // Datapath for the current chunk
    logic [CHUNK-1:0] x_ch;
    logic [CHUNK-1:0] y_ch;
    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] z_run;
    logic             last_chunk;
    logic             zero_plain;
    logic             zero_res;

    always_comb begin
        x_ch  = '0;
        y_ch  = '0;
        z_run = z_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (k_q == KW'(i)) begin
                x_ch = x_q[i*CHUNK +: CHUNK];
                y_ch = yeff_q[i*CHUNK +: CHUNK];
            end
        end
        csum = {1'b0, x_ch} + {1'b0, y_ch} + (CHUNK+1)'(carry_q);
        // z_run is z with the current chunk merged in; on the last chunk it
        // is the complete result, so the flags are derived from it directly.
        for (int unsigned i = 0; i < NCH; i++) begin
            if (k_q == KW'(i)) begin
                z_run[i*CHUNK +: CHUNK] = csum[CHUNK-1:0];
            end
        end
        last_chunk = (k_q == KW'(NCH - 1));
        zero_plain = (z_run == '0);
`ifdef ZERO_CHAIN_EN
        zero_res = op_q[1] ? (zero_plain && zstore_q) : zero_plain;
`else
        zero_res = zero_plain;
`endif
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        yeff_d       = yeff_q;
        op_d         = op_q;
        k_d          = k_q;
        carry_d      = carry_q;
        z_d          = z_q;
        out_valid_d  = out_valid_q;
        c_out_d      = c_out_q;
        overflow_d   = overflow_q;
        negative_d   = negative_q;
        zero_d       = zero_q;
        carry_flag_d = carry_flag_q;
        zstore_d     = zstore_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    yeff_d  = y ^ {WIDTH{op[0]}};
                    // ADD 0, SUB 1, ADC/SBC take the stored carry
                    carry_d = op[1] ? carry_flag_q : op[0];
                    op_d    = op;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                z_d     = z_run;
                carry_d = csum[CHUNK];
                if (last_chunk) begin
                    state_d      = S_DONE;
                    out_valid_d  = 1'b1;
                    c_out_d      = csum[CHUNK];
                    overflow_d   = (x_q[WIDTH-1] == yeff_q[WIDTH-1]) &&
                                   (z_run[WIDTH-1] != x_q[WIDTH-1]);
                    negative_d   = z_run[WIDTH-1];
                    zero_d       = zero_res;
                    carry_flag_d = csum[CHUNK];
                    zstore_d     = zero_res;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            yeff_q       <= '0;
            op_q         <= '0;
            k_q          <= '0;
            carry_q      <= 1'b0;
            z_q          <= '0;
            out_valid_q  <= 1'b0;
            c_out_q      <= 1'b0;
            overflow_q   <= 1'b0;
            negative_q   <= 1'b0;
            zero_q       <= 1'b0;
            carry_flag_q <= 1'b0;
            zstore_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            yeff_q       <= yeff_d;
            op_q         <= op_d;
            k_q          <= k_d;
            carry_q      <= carry_d;
            z_q          <= z_d;
            out_valid_q  <= out_valid_d;
            c_out_q      <= c_out_d;
            overflow_q   <= overflow_d;
            negative_q   <= negative_d;
            zero_q       <= zero_d;
            carry_flag_q <= carry_flag_d;
            zstore_q     <= zstore_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign z          = z_q;
    assign c_out      = c_out_q;
    assign overflow   = overflow_q;
    assign negative   = negative_q;
    assign zero       = zero_q;
    assign carry_flag = carry_flag_q;

endmodule
